// File: rtl/dmd_pkg.sv
// Shared DMD frame-buffer definitions: geometry, write-controller states and the
// BRAM address packing used by both the frame writer and the display reader.
package dmd_pkg;

   localparam int DMD_COLS   = 128;
   localparam int DMD_ROWS   = 32;
   localparam int DMD_PIX_W  = 4;
   localparam int DMD_ADDR_W = 13;

   localparam int DMD_X_W    = $clog2(DMD_COLS);
   localparam int DMD_Y_W    = $clog2(DMD_ROWS);
   localparam int DMD_CNT_W  = DMD_X_W + DMD_Y_W;
   localparam int DMD_PIXELS = DMD_COLS * DMD_ROWS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_FILL,
      ST_SWAP_WAIT
   } dmd_state_e;

   function automatic logic [DMD_ADDR_W-1:0] dmd_pack_addr(
      input logic               bank,
      input logic [DMD_Y_W-1:0] y,
      input logic [DMD_X_W-1:0] x
   );
      return {bank, y, x};
   endfunction

endpackage

// File: rtl/dmd_frame_writer_if.sv
// Capture stream, fill request, vsync and BRAM port A of the DMD frame writer.
// master = stream/timing source side, slave = the frame writer.
interface dmd_frame_writer_if;
   import dmd_pkg::*;

   logic                  cap_valid;
   logic                  cap_ready;
   logic                  cap_sof;
   logic [DMD_PIX_W-1:0]  cap_pix;
   logic                  fill_start;
   logic [DMD_PIX_W-1:0]  fill_value;
   logic                  vsync;
   logic                  wea;
   logic [DMD_ADDR_W-1:0] addra;
   logic [DMD_PIX_W-1:0]  dina;
   logic                  disp_bank;
   logic                  frame_done;
   logic                  sync_err;

   modport master (
      output cap_valid, cap_sof, cap_pix, fill_start, fill_value, vsync,
      input  cap_ready, wea, addra, dina, disp_bank, frame_done, sync_err
   );

   modport slave (
      input  cap_valid, cap_sof, cap_pix, fill_start, fill_value, vsync,
      output cap_ready, wea, addra, dina, disp_bank, frame_done, sync_err
   );

endinterface

// File: rtl/dmd_pix_counter.sv
// Raster pixel counter for one bank: clear, load-to-1 (pixel 0 written this cycle)
// and increment; split into x/y and flags the last pixel of the frame.
module dmd_pix_counter
   import dmd_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_load1,
   input  logic               i_inc,
   output logic [DMD_X_W-1:0] o_x,
   output logic [DMD_Y_W-1:0] o_y,
   output logic               o_last
);

   logic [DMD_CNT_W-1:0] r_count;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_load1) begin
         r_count <= DMD_CNT_W'(1);
      end else if (i_inc) begin
         r_count <= r_count + DMD_CNT_W'(1);
      end
   end

   assign o_x    = r_count[DMD_X_W-1:0];
   assign o_y    = r_count[DMD_CNT_W-1:DMD_X_W];
   assign o_last = (r_count == DMD_CNT_W'(DMD_PIXELS - 1));

endmodule

// File: rtl/dmd_frame_writer.sv
// Double-buffered DMD frame writer: owns BRAM port A, writes capture or fill data
// into the back bank and swaps banks only on vsync once a whole frame is written.
module dmd_frame_writer
   import dmd_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   dmd_frame_writer_if.slave  bus
);

   dmd_state_e            r_state;
   dmd_state_e            w_state_nxt;
   logic                  r_disp_bank;
   logic                  r_wea;
   logic [DMD_ADDR_W-1:0] r_addra;
   logic [DMD_PIX_W-1:0]  r_dina;
   logic [DMD_PIX_W-1:0]  r_fill_value;
   logic                  r_frame_done;
   logic                  r_sync_err;

   logic                  w_cap_ready;
   logic                  w_accept;
   logic                  w_cnt_clear;
   logic                  w_cnt_load1;
   logic                  w_cnt_inc;
   logic [DMD_X_W-1:0]    w_x;
   logic [DMD_Y_W-1:0]    w_y;
   logic                  w_last;
   logic                  w_wr;
   logic                  w_wr_zero;
   logic [DMD_PIX_W-1:0]  w_wr_data;
   logic                  w_sync_err;
   logic                  w_swap;
   logic                  w_fill_latch;

   dmd_pix_counter u_pix_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_cnt_clear),
      .i_load1 (w_cnt_load1),
      .i_inc   (w_cnt_inc),
      .o_x     (w_x),
      .o_y     (w_y),
      .o_last  (w_last)
   );

   assign w_cap_ready = !rst && (r_state == ST_IDLE || r_state == ST_CAPTURE);
   assign w_accept    = bus.cap_valid && w_cap_ready;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_clear  = 1'b0;
      w_cnt_load1  = 1'b0;
      w_cnt_inc    = 1'b0;
      w_wr         = 1'b0;
      w_wr_zero    = 1'b0;
      w_wr_data    = bus.cap_pix;
      w_sync_err   = 1'b0;
      w_swap       = 1'b0;
      w_fill_latch = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept && bus.cap_sof) begin
               w_wr        = 1'b1;
               w_wr_zero   = 1'b1;
               w_cnt_load1 = 1'b1;
               w_state_nxt = ST_CAPTURE;
            end else begin
               w_sync_err = w_accept;
               // Pixel 0 of a fill is issued right away so the first write lands next cycle.
               if (bus.fill_start) begin
                  w_fill_latch = 1'b1;
                  w_wr         = 1'b1;
                  w_wr_zero    = 1'b1;
                  w_wr_data    = bus.fill_value;
                  w_cnt_load1  = 1'b1;
                  w_state_nxt  = ST_FILL;
               end
            end
         end
         ST_CAPTURE: begin
            if (w_accept) begin
               w_wr = 1'b1;
               if (bus.cap_sof) begin
                  w_wr_zero   = 1'b1;
                  w_cnt_load1 = 1'b1;
                  w_sync_err  = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
                  if (w_last) begin
                     w_state_nxt = ST_SWAP_WAIT;
                  end
               end
            end
         end
         ST_FILL: begin
            w_wr      = 1'b1;
            w_wr_data = r_fill_value;
            w_cnt_inc = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_SWAP_WAIT;
            end
         end
         ST_SWAP_WAIT: begin
            if (bus.vsync) begin
               w_swap      = 1'b1;
               w_cnt_clear = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_disp_bank  <= 1'b0;
         r_wea        <= 1'b0;
         r_addra      <= '0;
         r_dina       <= '0;
         r_fill_value <= '0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wea        <= w_wr;
         r_frame_done <= w_swap;
         r_sync_err   <= w_sync_err;
         if (w_swap) begin
            r_disp_bank <= ~r_disp_bank;
         end
         if (w_fill_latch) begin
            r_fill_value <= bus.fill_value;
         end
         // Writes always target the back bank, which is never the one on screen.
         if (w_wr) begin
            r_addra <= dmd_pack_addr(~r_disp_bank,
                                     w_wr_zero ? '0 : w_y,
                                     w_wr_zero ? '0 : w_x);
            r_dina  <= w_wr_data;
         end
      end
   end

   assign bus.cap_ready  = w_cap_ready;
   assign bus.wea        = r_wea;
   assign bus.addra      = r_addra;
   assign bus.dina       = r_dina;
   assign bus.disp_bank  = r_disp_bank;
   assign bus.frame_done = r_frame_done;
   assign bus.sync_err   = r_sync_err;

endmodule

// File: doc/dmd_frame_writer.md
# dmd_frame_writer

Write-side controller for the 4-bit-per-pixel DMD frame buffer BRAM. It owns BRAM port A (wea/addra/dina), which the display path leaves unused, and shares it between a raster-order capture stream and an internal fill/clear engine. It double-buffers the memory: two 128x32 banks, with writes always going to the back bank. Banks swap only on a display vsync pulse, so the screen generator reading port B never shows a torn frame.

## Interface
- ADDR_W, 13, BRAM address width; bit 12 is the bank select.
- DATA_W, 4, pixel brightness width.
- COLS, 128, pixels per row.
- ROWS, 32, rows per frame; COLS*ROWS = 4096 pixels per bank.
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  capture pixel valid.
- cap_ready  out  1  capture pixel accepted when cap_valid && cap_ready.
- cap_sof  in  1  start of frame; qualifies the first pixel of a frame.
- cap_pix  in  DATA_W  capture pixel brightness.
- fill_start  in  1  one-cycle request to fill the back bank.
- fill_value  in  DATA_W  fill brightness, sampled with fill_start.
- vsync  in  1  one-cycle pulse from display timing, at frame boundary.
- wea  out  1  BRAM port A write enable.
- addra  out  ADDR_W  BRAM port A address = {back_bank, y[4:0], x[6:0]}.
- dina  out  DATA_W  BRAM port A write data.
- disp_bank  out  1  bank the display reads; drives addrb[12].
- frame_done  out  1  one-cycle pulse when a swap occurs.
- sync_err  out  1  one-cycle pulse on a capture framing error.

## Operation
- FSM states: IDLE, CAPTURE, FILL, SWAP_WAIT. back_bank is always ~disp_bank.
- IDLE:
  - Accepted pixel with cap_sof: write it to pixel 0, set count to 1, go to CAPTURE.
  - Accepted pixel without cap_sof: drop it, no write, pulse sync_err.
  - fill_start: latch fill_value, set count to 0, go to FILL.
  - fill_start together with an accepted cap_sof pixel: capture wins; fill_start is ignored.
- CAPTURE:
  - Each accepted pixel writes to address count, then count increments.
  - The pixel at count 4095 is the last one; after it, go to SWAP_WAIT.
  - cap_sof mid-frame: that pixel writes to pixel 0, count becomes 1, pulse sync_err (frame restart).
  - fill_start is ignored.
- FILL:
  - Writes the latched value to one address per cycle, 0..4095, then goes to SWAP_WAIT.
  - cap_ready = 0 throughout.
- SWAP_WAIT:
  - cap_ready = 0.
  - On vsync: toggle disp_bank, pulse frame_done, go to IDLE.
- cap_ready = !rst && (state == IDLE || state == CAPTURE).
- Count is 12 bits; x = count[6:0], y = count[11:7]; wraps naturally at 4096. No other arithmetic.

## Timing
- Write latency is 1 cycle: wea/addra/dina are registered and appear the cycle after acceptance (or after the FILL count step). wea is high for exactly one cycle per write.
- Fill: first write one cycle after fill_start; 4096 consecutive wea cycles; SWAP_WAIT entered the cycle after the last write is issued.
- vsync is honoured only while in SWAP_WAIT. A vsync coinciding with the transition into SWAP_WAIT is ignored. disp_bank and frame_done change one cycle after the qualifying vsync.
- A swap never occurs while wea is high for the same bank transition: the final write completes before SWAP_WAIT is entered.
- Reset values: state IDLE, disp_bank 0 (back bank 1), count 0, wea 0, addra 0, dina 0, frame_done 0, sync_err 0.
- Reset mid-CAPTURE or mid-FILL aborts the frame with no further writes from the next cycle. The partially written bank is not swapped in.

## Structure
- Shared package dmd_pkg:
  - DMD_COLS = 128, DMD_ROWS = 32, DMD_PIX_W = 4, DMD_ADDR_W = 13.
  - FSM state enum.
  - Address-pack function {bank, y, x}. The display reader uses the same function for addrb.
- One sub-module: dmd_pix_counter, the 12-bit counter with clear, load-to-1 and increment, exposing x, y and last (count == 4095).
- The BRAM itself is instantiated outside this block.

## Test plan
- Reset, then fill_start with fill_value=4'hA: 4096 writes to addra 0x1000..0x1FFF with dina=0xA. Next vsync: disp_bank=1, frame_done pulses once.
- Capture 4096 pixels, pixel i = i[3:0], cap_sof on the first: writes to back bank in raster order; pixel (x=5, y=3) lands at {bank,5'd3,7'd5} with value 0x5. cap_ready drops after the last pixel.
- Pixels without cap_sof in IDLE: no wea, sync_err pulses per pixel. cap_sof after 100 pixels: that pixel is written at pixel 0, sync_err pulses once.
- vsync held off 1000 cycles after a full frame: cap_ready=0, no writes, disp_bank unchanged; swap occurs one cycle after vsync.
- fill_start and a cap_sof pixel in the same IDLE cycle: capture runs and the fill is ignored. fill_start during CAPTURE is ignored.
- rst asserted at fill pixel 2000: wea=0 from the next cycle, disp_bank=0, state IDLE, no frame_done.
